half_multiply: RTL and testbench

// - Multi-cycle IEEE-754 binary16 multiplier: c = a * b, paired with the divide

---
 rtl/half_pkg.sv | 43 ++++
 rtl/shift_add_multiply.sv | 65 ++++++
 rtl/half_multiply.sv | 145 ++++++++++++++
 tb/tb_half_multiply.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/half_pkg.sv
// Shared binary16 constants, field layout and operand classification for the
// half-precision multiply/divide datapath.
package half_pkg;

   localparam int HALF_EXP_W  = 5;
   localparam int HALF_MANT_W = 10;
   localparam int HALF_SIG_W  = HALF_MANT_W + 1;

   localparam logic [HALF_EXP_W-1:0] HALF_EXP_BIAS = 5'd15;
   localparam logic [HALF_EXP_W-1:0] HALF_EXP_MAX  = 5'd31;
   localparam logic [15:0]           HALF_QNAN     = 16'h7E00;
   localparam logic [15:0]           HALF_PINF     = 16'h7C00;

   typedef struct packed {
      logic                   sign;
      logic [HALF_EXP_W-1:0]  exp;
      logic [HALF_MANT_W-1:0] mant;
   } half_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_NORM,
      ST_DONE
   } mul_state_t;

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_NORM,
      CLS_INF
   } half_class_t;

   // Subnormals collapse to zero; every exp==31 encoding behaves as infinity.
   function automatic half_class_t classify(input half_t h);
      if (h.exp == '0)
         return CLS_ZERO;
      else if (h.exp == HALF_EXP_MAX)
         return CLS_INF;
      else
         return CLS_NORM;
   endfunction

endpackage

// File: rtl/shift_add_multiply.sv
// Unsigned iterative shift-add multiplier; consumes BITS_PER_CYCLE multiplier
// bits per cycle after a start pulse and holds done until the next start.
module shift_add_multiply #(
   parameter int WIDTH          = 11,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] p
);

   localparam int ITERS = (WIDTH + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
   localparam int MW    = ITERS * BITS_PER_CYCLE;
   localparam int AW    = WIDTH + MW;
   localparam int CW    = $clog2(ITERS + 1);

   logic [AW-1:0] acc_p0;
   logic [AW-1:0] mcand_p0;
   logic [MW-1:0] mplier_p0;
   logic [AW-1:0] addend;
   logic [CW-1:0] cnt;
   logic          busy;
   logic          step;

   assign step = busy && (cnt != '0);
   assign done = busy && (cnt == '0);
   assign p    = acc_p0[2*WIDTH-1:0];

   always_comb begin
      addend = '0;
      for (int j = 0; j < BITS_PER_CYCLE; j++)
         if (mplier_p0[j])
            addend = addend + (mcand_p0 << j);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start) begin
         busy <= 1'b1;
         cnt  <= CW'(ITERS);
      end else if (step) begin
         cnt  <= cnt - 1'b1;
      end
   end

   // Iteration stage: accumulate the current digit, then advance both operands.
   always_ff @(posedge clk) begin
      if (start) begin
         acc_p0    <= '0;
         mcand_p0  <= AW'(a);
         mplier_p0 <= MW'(b);
      end else if (step) begin
         acc_p0    <= acc_p0 + addend;
         mcand_p0  <= mcand_p0 << BITS_PER_CYCLE;
         mplier_p0 <= mplier_p0 >> BITS_PER_CYCLE;
      end
   end

endmodule

// File: rtl/half_multiply.sv
// Multi-cycle binary16 multiplier with ready/valid handshakes.
// Optional HALF_MULTIPLY_ROUND_EN selects round-to-nearest-even instead of truncation.
module half_multiply
   import half_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] c
);

   mul_state_t state, state_nxt;
   half_t      a_p0, b_p0;
   logic       accept;
   logic       mul_done;
   logic [2*HALF_SIG_W-1:0] prod;

   logic                   sign;
   half_class_t            cls_a, cls_b;
   logic signed [6:0]      e_sum, e_norm, e_fin;
   logic [HALF_MANT_W-1:0] mant_t, mant_fin;
   logic [15:0]            result;

`ifdef HALF_MULTIPLY_ROUND_EN
   logic        grd, stk;
   logic [10:0] rnd;

   function automatic logic [10:0] round_rne(input logic [9:0] mant,
                                             input logic g, input logic s);
      logic up;
      up = g & (s | mant[0]);
      return {1'b0, mant} + {10'd0, up};
   endfunction
`else
   logic unused_lsbs;
   assign unused_lsbs = ^prod[9:0];
`endif

   // Finite results never produce subnormals: underflow flushes, overflow saturates to inf.
   function automatic logic [15:0] pack_finite(input logic sgn,
                                               input logic signed [6:0] e,
                                               input logic [9:0] mant);
      if (e <= 7'sd0)
         return {sgn, 15'd0};
      else if (e >= 7'sd31)
         return {sgn, HALF_EXP_MAX, 10'd0};
      else
         return {sgn, e[4:0], mant};
   endfunction

   assign accept = in_valid && in_ready;

   shift_add_multiply #(
      .WIDTH          (HALF_SIG_W),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_sig_mul (
      .clk   (clk),
      .rst   (rst),
      .start (accept),
      .a     ({1'b1, a[9:0]}),
      .b     ({1'b1, b[9:0]}),
      .done  (mul_done),
      .p     (prod)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_nxt = ST_MUL;
         end
         ST_MUL:  if (mul_done) state_nxt = ST_NORM;
         ST_NORM: state_nxt = ST_DONE;
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Capture stage: operands held for the special-case and exponent logic.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_p0 <= half_t'(a);
         b_p0 <= half_t'(b);
      end
   end

   always_comb begin
      sign   = a_p0.sign ^ b_p0.sign;
      cls_a  = classify(a_p0);
      cls_b  = classify(b_p0);
      e_sum  = $signed({2'b00, a_p0.exp}) + $signed({2'b00, b_p0.exp})
               - $signed({2'b00, HALF_EXP_BIAS});
      e_norm = prod[21] ? e_sum + 7'sd1 : e_sum;
      mant_t = prod[21] ? prod[20:11] : prod[19:10];
`ifdef HALF_MULTIPLY_ROUND_EN
      grd      = prod[21] ? prod[10] : prod[9];
      stk      = prod[21] ? |prod[9:0] : |prod[8:0];
      rnd      = round_rne(mant_t, grd, stk);
      e_fin    = rnd[10] ? e_norm + 7'sd1 : e_norm;
      mant_fin = rnd[9:0];
`else
      e_fin    = e_norm;
      mant_fin = mant_t;
`endif
      if ((cls_a == CLS_ZERO && cls_b == CLS_INF) || (cls_a == CLS_INF && cls_b == CLS_ZERO))
         result = HALF_QNAN;
      else if (cls_a == CLS_INF || cls_b == CLS_INF)
         result = {sign, HALF_PINF[14:0]};
      else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO)
         result = {sign, 15'd0};
      else
         result = pack_finite(sign, e_fin, mant_fin);
   end

   // Normalise/pack stage: result registered once, held through DONE.
   always_ff @(posedge clk) begin
      if (rst)
         c <= 16'h0000;
      else if (state == ST_NORM)
         c <= result;
   end

endmodule

// File: tb/tb_half_multiply.sv
// Directed bench for half_multiply: reset, arithmetic vectors, specials,
// rounding, back-pressure and mid-operation reset.
module tb_half_multiply;

   localparam int EXP_LAT = 13;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] c;

   int checks = 0;
   int passes = 0;

   half_multiply #(.BITS_PER_CYCLE(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one operation from IDLE and drains it; lat = -1 on timeout.
   task automatic do_op(input logic [15:0] ia, input logic [15:0] ib,
                        output logic [15:0] oc, output int lat);
      a        = ia;
      b        = ib;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat      = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      oc = c;
      if (!out_valid) lat = -1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      a         = 16'h3C00;
      b         = 16'h3C00;
      tick();
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else passes++;
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else passes++;
      checks++; if (c !== 16'h0000) $display("FAIL reset_c got=%h want=0000", c); else passes++;
   endtask

   task automatic test_basic();
      logic [15:0] r;
      int lat;
      do_op(16'h3C00, 16'h3C00, r, lat);
      checks++; if (r !== 16'h3C00) $display("FAIL one_x_one got=%h want=3C00", r); else passes++;
      checks++; if (lat != EXP_LAT) $display("FAIL latency got=%0d want=%0d", lat, EXP_LAT); else passes++;
   endtask

   task automatic test_vectors();
      logic [15:0] va [10];
      logic [15:0] vb [10];
      logic [15:0] vc [10];
      logic [15:0] r;
      int lat;
      va = '{16'h4000, 16'h0000, 16'h8000, 16'h7BFF, 16'h0400,
             16'h8400, 16'h7C00, 16'hFC00, 16'h0001, 16'h4200};
      vb = '{16'hC200, 16'h4500, 16'h4500, 16'h4000, 16'h0400,
             16'h0400, 16'h0000, 16'h4000, 16'h3C00, 16'h4200};
      vc = '{16'hC600, 16'h0000, 16'h8000, 16'h7C00, 16'h0000,
             16'h8000, 16'h7E00, 16'hFC00, 16'h0000, 16'h4880};
      for (int i = 0; i < 10; i++) begin
         do_op(va[i], vb[i], r, lat);
         checks++;
         if (r !== vc[i] || lat != EXP_LAT)
            $display("FAIL vec%0d %h*%h got=%h lat=%0d want=%h lat=%0d",
                     i, va[i], vb[i], r, lat, vc[i], EXP_LAT);
         else passes++;
      end
   endtask

   task automatic test_rounding();
      logic [15:0] r;
      logic [15:0] want;
      int lat;
`ifdef HALF_MULTIPLY_ROUND_EN
      want = 16'h3E02;
`else
      want = 16'h3E01;
`endif
      do_op(16'h3C01, 16'h3E00, r, lat);
      checks++; if (r !== want) $display("FAIL round_tie got=%h want=%h", r, want); else passes++;
   endtask

   task automatic test_back_to_back_pressure();
      int n;
      a        = 16'h4000;
      b        = 16'hC200;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) $display("FAIL busy_in_ready got=%b want=0", in_ready); else passes++;
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      checks++; if (out_valid !== 1'b1) $display("FAIL bp_timeout got=%b want=1", out_valid); else passes++;
      for (int k = 0; k < 5; k++) begin
         a        = 16'h3C00;
         b        = 16'h3C00;
         in_valid = k[0];
         checks++;
         if (out_valid !== 1'b1 || c !== 16'hC600 || in_ready !== 1'b0)
            $display("FAIL hold%0d got v=%b c=%h rdy=%b want v=1 c=C600 rdy=0",
                     k, out_valid, c, in_ready);
         else passes++;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL drain got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
      else passes++;
      for (int k = 0; k < 16; k++) tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL not_queued got=%b want=0", out_valid); else passes++;
   endtask

   task automatic test_reset_mid();
      logic [15:0] r;
      int lat;
      a        = 16'h7BFF;
      b        = 16'h4000;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || c !== 16'h0000)
         $display("FAIL mid_reset got v=%b rdy=%b c=%h want v=0 rdy=1 c=0000",
                  out_valid, in_ready, c);
      else passes++;
      for (int k = 0; k < 16; k++) tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL mid_reset_stale got=%b want=0", out_valid); else passes++;
      do_op(16'h4000, 16'h4000, r, lat);
      checks++;
      if (r !== 16'h4400 || lat != EXP_LAT)
         $display("FAIL after_reset got=%h lat=%0d want=4400 lat=%0d", r, lat, EXP_LAT);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_vectors();
      test_rounding();
      test_back_to_back_pressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
